// File: rtl/hs_arbiter.sv
// hs_arbiter: N-input arbiter that funnels four-phase requesters into one
// shared downstream fifostage port, one word at a time.
// Build option: define HSARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); the default build uses round-robin arbitration.
module hs_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int GW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    rr,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    ar,
  output logic [W-1:0]    dout,
  output logic            rw,
  input  logic            aw,
  output logic [GW-1:0]   gnt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RACK = 2'd1,
    WREQ = 2'd2,
    WREL = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t        state;
  logic [GW-1:0] sel;

`ifdef HSARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index wins.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rr[GW'(i)]) sel = GW'(i);
    end
  end
`else
  logic [GW-1:0] last;
  logic [GW-1:0] cand;
  logic          found;
  int            idx;

  // Round-robin: first requester found searching upward from last+1, wrapping.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx  = (int'(last) + k) % N;
      cand = GW'(idx);
      if (!found && rr[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  // Handshake sequencer: grant and capture, release requester, write downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ar    <= '0;
      rw    <= 1'b0;
      dout  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
`ifndef HSARB_FIXED_PRIO_EN
      last  <= GW'(N - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|rr) begin
            dout  <= din[int'(sel)*W +: W];
            gnt   <= sel;
            ar    <= ONE << sel;
            busy  <= 1'b1;
            state <= RACK;
          end
        end
        RACK: begin
          if (!rr[gnt]) begin
            ar    <= '0;
            rw    <= 1'b1;
            state <= WREQ;
          end
        end
        WREQ: begin
          if (aw) begin
            rw    <= 1'b0;
            state <= WREL;
          end
        end
        WREL: begin
          if (!aw) begin
            busy  <= 1'b0;
            state <= IDLE;
`ifndef HSARB_FIXED_PRIO_EN
            last  <= gnt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_arbiter.sv
// tb_hs_arbiter: table-driven and hand-written sequences for hs_arbiter,
// with a scoreboard of expected {data, grant} words checked at the downstream.
module tb_hs_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   rr = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   ar;
  logic [W-1:0]   dout;
  logic           rw;
  logic           aw = 1'b0;
  logic [1:0]     gnt;
  logic           busy;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          count;
    logic [7:0]  order;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] gnt;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   auto_mode = 1'b0;
  int   cnt[N];
  int   stall = 0;

  hs_arbiter #(.N(N), .W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .rr   (rr),
    .din  (din),
    .ar   (ar),
    .dout (dout),
    .rw   (rw),
    .aw   (aw),
    .gnt  (gnt),
    .busy (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Requester and downstream partner models, evaluated once per falling edge.
  task automatic runModels();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (rr[i] && ar[i]) begin
        rr[i] = 1'b0;
      end else if (!rr[i] && !ar[i] && cnt[i] > 0) begin
        rr[i] = 1'b1;
        cnt[i]--;
      end
    end
    if (rw && !aw) begin
      if (stall > 0) begin
        stall--;
      end else begin
        aw = 1'b1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: actual word %0h gnt %0d required none", dout, gnt);
        end else begin
          e = sbq.pop_front();
          checkOutput("sb_dout", 32'(dout), 32'(e.data));
          checkOutput("sb_gnt", 32'(gnt), 32'(e.gnt));
        end
      end
    end else if (!rw && aw) begin
      aw = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (auto_mode) runModels();
  endtask

  task automatic doReset();
    reset = 1'b0;
    rr = '0;
    aw = 1'b0;
    auto_mode = 1'b0;
    stall = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    sbq.delete();
    tick();
    tick();
    checkOutput("rst_ar", 32'(ar), 32'h0);
    checkOutput("rst_rw", 32'(rw), 32'h0);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
  endtask

  // Loads requester data, arms the requesters in the mask and queues the expected words.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] dw;
    int g;
    dw = v.data;
    din = dw;
    for (int k = 0; k < v.count; k++) begin
      g = int'(v.order[2*k +: 2]);
      sbq.push_back('{data: dw[g*8 +: 8], gnt: 2'(g)});
    end
    for (int i = 0; i < N; i++) begin
      if (v.mask[i]) cnt[i] = cnt[i] + 1;
    end
  endtask

  task automatic waitDone(input string name);
    bit done;
    int pending;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      pending = 0;
      for (int i = 0; i < N; i++) pending += cnt[i];
      if (sbq.size() == 0 && pending == 0 && rr == '0 && !busy && !aw) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checkOutput({name, "_done"}, 32'(done), 32'h1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] cont_order[8];

`ifdef HSARB_FIXED_PRIO_EN
    vecs[0] = '{4'b0001, 32'h000000A5, 1, 8'h00};
    vecs[1] = '{4'b0010, 32'h00005A00, 1, 8'h01};
    vecs[2] = '{4'b0110, 32'h55667788, 2, 8'h09};
    vecs[3] = '{4'b1001, 32'h9F0000E1, 2, 8'h0C};
    vecs[4] = '{4'b1111, 32'h44332211, 4, 8'hE4};
    vecs[5] = '{4'b1000, 32'hDE000000, 1, 8'h03};
    cont_order = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
`else
    vecs[0] = '{4'b0001, 32'h000000A5, 1, 8'h00};
    vecs[1] = '{4'b0010, 32'h00005A00, 1, 8'h01};
    vecs[2] = '{4'b0110, 32'h55667788, 2, 8'h06};
    vecs[3] = '{4'b1001, 32'h9F0000E1, 2, 8'h03};
    vecs[4] = '{4'b1111, 32'h44332211, 4, 8'h39};
    vecs[5] = '{4'b1000, 32'hDE000000, 1, 8'h03};
    cont_order = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
`endif

    // Single request with a zero-delay downstream, driven by hand.
    doReset();
    din = 32'h000000A5;
    rr = 4'b0001;
    tick();
    checkOutput("single_ar", 32'(ar), 32'h1);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_rw_low", 32'(rw), 32'h0);
    rr = 4'b0000;
    tick();
    checkOutput("single_ar_drop", 32'(ar), 32'h0);
    checkOutput("single_rw", 32'(rw), 32'h1);
    checkOutput("single_dout", 32'(dout), 32'hA5);
    checkOutput("single_gnt", 32'(gnt), 32'h0);
    aw = 1'b1;
    tick();
    checkOutput("single_rw_rel", 32'(rw), 32'h0);
    checkOutput("single_busy_wrel", 32'(busy), 32'h1);
    aw = 1'b0;
    tick();
    checkOutput("single_busy_end", 32'(busy), 32'h0);
    checkOutput("single_dout_hold", 32'(dout), 32'hA5);

    // Spurious aw while idle must not start anything.
    aw = 1'b1;
    tick();
    tick();
    checkOutput("spur_rw", 32'(rw), 32'h0);
    checkOutput("spur_busy", 32'(busy), 32'h0);
    checkOutput("spur_ar", 32'(ar), 32'h0);
    aw = 1'b0;
    tick();

    // Table of request patterns with expected grant order.
    doReset();
    auto_mode = 1'b1;
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v]);
      waitDone($sformatf("vec%0d", v));
    end

    // All four requesters asking continuously, two words each.
    doReset();
    auto_mode = 1'b1;
    din = 32'h13121110;
    for (int k = 0; k < 8; k++) begin
      e.gnt = 2'(cont_order[k]);
      e.data = 8'h10 + cont_order[k];
      sbq.push_back(e);
    end
    for (int i = 0; i < N; i++) cnt[i] = 2;
    waitDone("continuous");

    // Downstream stalls for 10 cycles; a new request must wait for IDLE.
    doReset();
    din = 32'h0000003C;
    rr = 4'b0001;
    tick();
    checkOutput("stall_ar0", 32'(ar), 32'h1);
    rr = 4'b0000;
    tick();
    checkOutput("stall_rw", 32'(rw), 32'h1);
    din = 32'h7700003C;
    rr = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput($sformatf("stall_rw_c%0d", c), 32'(rw), 32'h1);
      checkOutput($sformatf("stall_dout_c%0d", c), 32'(dout), 32'h3C);
      checkOutput($sformatf("stall_ar_c%0d", c), 32'(ar), 32'h0);
    end
    aw = 1'b1;
    tick();
    checkOutput("stall_rw_rel", 32'(rw), 32'h0);
    checkOutput("stall_ar_wrel", 32'(ar), 32'h0);
    aw = 1'b0;
    tick();
    checkOutput("stall_ar_idle", 32'(ar), 32'h0);
    tick();
    checkOutput("stall_ar3", 32'(ar), 32'h8);
    checkOutput("stall_gnt3", 32'(gnt), 32'h3);
    rr = 4'b0000;
    tick();
    checkOutput("stall_rw3", 32'(rw), 32'h1);
    checkOutput("stall_dout3", 32'(dout), 32'h77);
    aw = 1'b1;
    tick();
    aw = 1'b0;
    tick();
    checkOutput("stall_busy_end", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a downstream write.
    doReset();
    din = 32'h005C0000;
    rr = 4'b0100;
    tick();
    checkOutput("arst_ar2", 32'(ar), 32'h4);
    rr = 4'b0000;
    tick();
    checkOutput("arst_rw_pre", 32'(rw), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_rw", 32'(rw), 32'h0);
    checkOutput("arst_ar", 32'(ar), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_dout", 32'(dout), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    din = 32'h44332211;
    rr = 4'b1111;
    tick();
    checkOutput("arst_prio_ar", 32'(ar), 32'h1);
    checkOutput("arst_prio_gnt", 32'(gnt), 32'h0);
    checkOutput("arst_prio_dout", 32'(dout), 32'h11);
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_arbiter.md
Name: hs_arbiter

Overview:
- N-input round-robin arbiter for one shared fifostage input port.
- Each requester has a four-phase follower interface (rr/ar/din). The arbiter accepts one word at a time, then acts as initiator (rw/aw/dout) toward the downstream fifostage chain.
- It sequences both handshakes so that the shared stage sees exactly one transfer at a time.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, data width in bits
- GW, $clog2(N), width of the grant index output (derived, not overridden)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- rr  input  N  request-read per requester; bit i high = din word i valid
- din  input  N*W  requester data; word i at bits [i*W +: W]
- ar  output  N  ack-read per requester; at most one bit high
- dout  output  W  data to downstream fifostage din
- rw  output  1  request-write to downstream
- aw  input  1  ack-write from downstream
- gnt  output  GW  index of current/last granted requester
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - ar=0, rw=0, dout=0, gnt=0, busy=0.
  - state=IDLE; round-robin pointer last=N-1, so requester 0 has first priority.
- All inputs are synchronous to clk. There are no synchronisers; inputs are sampled on the rising edge.
- Four-phase rule, both sides: request rises → ack rises → request falls → ack falls. Data is stable while the request is high.
- States: IDLE, RACK, WREQ, WREL.
- IDLE:
  - On an edge with any rr bit high, select g = first i with rr[i]=1, searching from (last+1) mod N upward with wrap-around.
  - dout<=din[g], gnt<=g, ar[g]<=1, state<=RACK.
  - Word capture happens on this edge.
- RACK: hold ar[g]=1. On an edge with rr[g]=0: ar[g]<=0, rw<=1, state<=WREQ.
- WREQ: hold rw=1, dout stable. On an edge with aw=1: rw<=0, state<=WREL.
- WREL: on an edge with aw=0: last<=g, state<=IDLE.
- Next arbitration happens from IDLE only, giving at least one IDLE cycle between grants.
- Latency:
  - rr[g] rise to ar[g] rise: 1 cycle.
  - rr[g] fall sampled to rw rise: 1 cycle.
  - Minimum transfer with zero-delay partners: 4 cycles plus 1 IDLE cycle.
- Fairness: a requester holding rr continuously is served within N grants.
- Simultaneous requests: resolved purely by the rotating search above. Non-granted requesters see ar=0 and keep waiting.
- New requests arriving during RACK/WREQ/WREL are ignored until IDLE.
- aw=1 while in IDLE or RACK is a protocol violation: ignored, no state change.
- rr[g] rising again in WREQ/WREL is ignored; it is treated as a new request in IDLE.
- dout and gnt retain their values after the transfer until the next grant.
- reset asserted mid-operation: immediate return to reset values. The in-flight word is discarded, and the downstream side sees rw drop without completion. Partners must also be reset.

Optional Feature:
- Macro: HSARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. The last pointer is not used (it may be optimised away), and requester 0 can starve the others.
- Undefined (default): round-robin as above.
- Ports and timing are identical in both cases.

Test Plan:
- Reset then single request: rr=0001, din[0]=8'hA5, zero-delay downstream → ar[0] high 1 cycle after rr rises. After rr drops: rw=1 with dout=A5, gnt=0. Transfer completes and busy=0.
- All four request continuously (din[i]=8'h10+i) → downstream receives 10,11,12,13,10,… with grants in order 0,1,2,3,0.
- rr=0110 at the same edge after requester 1 was last served → grant 2, then 1. With HSARB_FIXED_PRIO_EN: grant 1, then 2.
- Downstream holds aw low for 10 cycles in WREQ → rw and dout stay stable for 10 cycles. A new rr[3] raised meanwhile gets no ar until WREL→IDLE.
- Reset pulled low during WREQ → rw, ar, busy go 0 asynchronously, before the next edge. After release, requester 0 has first priority.
- Spurious aw=1 in IDLE with rr=0 → no state change, rw=0, busy=0.
